// File: rtl/button_conditioner.sv
// Pushbutton front end: synchronises, debounces and edge-detects three raw
// buttons, then turns accepted presses into one-cycle Start/Stop/Clear commands.
module button_conditioner #(
  parameter int DebounceMax = 1000000,
  parameter int CountWidth  = 20
) (
  input  logic Clock,
  input  logic Reset,
  input  logic BtnStart,
  input  logic BtnStop,
  input  logic BtnReset,
  output logic Start,
  output logic Stop,
  output logic Clear,
  output logic Running
);

  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_RESET = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  localparam logic [CountWidth-1:0] COUNT_LAST = CountWidth'(DebounceMax - 1);

  logic [2:0]            w_raw;
  logic [2:0]            r_sync1;
  logic [2:0]            r_sync2;
  logic [2:0]            r_stable;
  logic [2:0]            r_edge;
  logic [CountWidth-1:0] r_count [3];

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       w_start;
  logic       w_stop;
  logic       w_clear;
  logic       r_start;
  logic       r_stop;
  logic       r_clear;
  logic       r_running;

  assign w_raw = {BtnReset, BtnStop, BtnStart};

  // Debounce: a level is accepted only after DebounceMax consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_edge   <= '0;
      // NOTE: the counters are ordinary flops, not RAM, so they are reset like
      // any other state; this is what cancels a debounce caught mid-count.
      for (int i = 0; i < 3; i++) r_count[i] <= '0;
    end else begin
      // NOTE: non-blocking so r_sync2 takes last cycle's r_sync1 and the two
      // synchroniser stages stay two distinct flops.
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        r_edge[i] <= 1'b0;
        if (r_sync2[i] == r_stable[i]) begin
          r_count[i] <= '0;
        end else if (r_count[i] < COUNT_LAST) begin
          r_count[i] <= r_count[i] + 1'b1;
        end else begin
          r_stable[i] <= r_sync2[i];
          r_count[i]  <= '0;
          r_edge[i]   <= r_sync2[i];
        end
      end
    end
  end

  // Command decode: reset edge beats stop edge beats start edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    w_clear      = 1'b0;
    if (r_edge[BTN_RESET]) begin
      w_next_state = ST_IDLE;
      w_clear      = 1'b1;
    end else if (r_edge[BTN_STOP]) begin
      if (r_state == ST_RUNNING) begin
        w_next_state = ST_STOPPED;
        w_stop       = 1'b1;
      end
    end else if (r_edge[BTN_START]) begin
      if (r_state != ST_RUNNING) begin
        w_next_state = ST_RUNNING;
        w_start      = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_clear   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_start   <= w_start;
      r_stop    <= w_stop;
      r_clear   <= w_clear;
      r_running <= (w_next_state == ST_RUNNING);
    end
  end

  assign Start   = r_start;
  assign Stop    = r_stop;
  assign Clear   = r_clear;
  assign Running = r_running;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: an event-level reference model
// compared every cycle, plus hand-timed literal expectations.
module tb_button_conditioner;

  localparam int DM = 4;

  logic Clock    = 1'b0;
  logic Reset    = 1'b1;
  logic BtnStart = 1'b0;
  logic BtnStop  = 1'b0;
  logic BtnReset = 1'b0;
  logic Start, Stop, Clear, Running;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  button_conditioner #(
    .DebounceMax(DM),
    .CountWidth (20)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .BtnStart(BtnStart),
    .BtnStop (BtnStop),
    .BtnReset(BtnReset),
    .Start   (Start),
    .Stop    (Stop),
    .Clear   (Clear),
    .Running (Running)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Reference model: a button level is accepted once its synchronised value
  // has disagreed with the accepted level for DM consecutive clock edges,
  // measured from the edge at which the disagreement began.
  typedef enum {M_IDLE, M_RUN, M_STOPPED} mstate_t;
  mstate_t    m_state   = M_IDLE;
  logic       m_start   = 1'b0;
  logic       m_stop    = 1'b0;
  logic       m_clear   = 1'b0;
  logic       m_running = 1'b0;
  logic [2:0] m_dly1    = '0;
  logic [2:0] m_dly2    = '0;
  logic [2:0] m_stable  = '0;
  logic [2:0] m_pulse   = '0;
  int         m_since [3] = '{-1, -1, -1};
  int         cyc = 0;

  always @(posedge Clock) begin
    logic [2:0] raw;
    logic [2:0] new_pulse;
    raw       = {BtnReset, BtnStop, BtnStart};
    new_pulse = '0;
    if (Reset) begin
      m_state = M_IDLE;
      {m_start, m_stop, m_clear, m_running} = 4'b0000;
      m_dly1 = '0; m_dly2 = '0; m_stable = '0; m_pulse = '0;
      for (int b = 0; b < 3; b++) m_since[b] = -1;
    end else begin
      {m_start, m_stop, m_clear} = 3'b000;
      if (m_pulse[2]) begin
        m_state = M_IDLE;
        m_clear = 1'b1;
      end else if (m_pulse[1]) begin
        if (m_state == M_RUN) begin
          m_state = M_STOPPED;
          m_stop  = 1'b1;
        end
      end else if (m_pulse[0] && m_state != M_RUN) begin
        m_state = M_RUN;
        m_start = 1'b1;
      end
      m_running = (m_state == M_RUN);
      for (int b = 0; b < 3; b++) begin
        if (m_dly2[b] == m_stable[b]) begin
          m_since[b] = -1;
        end else begin
          if (m_since[b] < 0) m_since[b] = cyc;
          if (cyc - m_since[b] + 1 >= DM) begin
            m_stable[b]  = m_dly2[b];
            m_since[b]   = -1;
            new_pulse[b] = m_dly2[b];
          end
        end
      end
      m_pulse = new_pulse;
      m_dly2  = m_dly1;
      m_dly1  = raw;
    end
    cyc++;
  end

  bit cmp_en = 1'b0;
  always @(negedge Clock) begin
    if (cmp_en)
      check("cycle_outputs{start,stop,clear,running}",
            {28'd0, Start, Stop, Clear, Running},
            {28'd0, m_start, m_stop, m_clear, m_running});
  end

  // Pulse tallies, sampled at the following rising edge.
  int n_start = 0;
  int n_stop  = 0;
  int n_clear = 0;
  always @(posedge Clock) begin
    if (cmp_en) begin
      if (Start === 1'b1) n_start++;
      if (Stop  === 1'b1) n_stop++;
      if (Clear === 1'b1) n_clear++;
    end
  end

  task automatic press(input int b, input int hold);
    case (b)
      0: BtnStart = 1'b1;
      1: BtnStop  = 1'b1;
      default: BtnReset = 1'b1;
    endcase
    step(hold);
    BtnStart = 1'b0;
    BtnStop  = 1'b0;
    BtnReset = 1'b0;
    step(10);
  endtask

  initial begin
    Reset = 1'b1;
    step(1);
    cmp_en = 1'b1;
    step(1);
    check("reset_outputs", {Start, Stop, Clear, Running}, 4'b0000);
    Reset = 1'b0;

    // Reset lands while the start counter sits at 2.
    BtnStart = 1'b1;
    step(4);
    Reset    = 1'b1;
    BtnStart = 1'b0;
    step(1);
    Reset = 1'b0;
    step(10);
    check("middebounce_no_start", n_start, 0);
    check("middebounce_running", Running, 0);

    // Held press: Start appears on the 7th falling edge after the input rises.
    BtnStart = 1'b1;
    step(6);
    check("hold_before_start", {Start, Running}, 2'b00);
    step(1);
    check("hold_start_pulse", {Start, Running}, 2'b11);
    step(1);
    check("hold_start_one_cycle", {Start, Running}, 2'b01);
    step(12);
    BtnStart = 1'b0;
    step(8);
    check("hold_single_start", n_start, 1);

    press(1, 6);
    check("stop_from_running", n_stop, 1);
    check("stop_running_low", Running, 0);
    press(1, 6);
    check("stop_in_stopped_ignored", n_stop, 1);
    check("stop_in_stopped_running", Running, 0);
    press(0, 6);
    check("restart_from_stopped", n_start, 2);
    check("restart_running", Running, 1);

    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    check("sync_reset_to_idle", {Start, Stop, Clear, Running}, 4'b0000);

    press(0, 3);
    check("glitch_no_start", n_start, 2);
    check("glitch_running", Running, 0);
    press(0, 4);
    check("four_cycle_press_start", n_start, 3);
    check("four_cycle_press_running", Running, 1);

    // All three rise together while running: only Clear survives.
    BtnStart = 1'b1;
    BtnStop  = 1'b1;
    BtnReset = 1'b1;
    step(6);
    check("all_before_clear", {Start, Stop, Clear, Running}, 4'b0001);
    step(1);
    check("all_clear_only", {Start, Stop, Clear, Running}, 4'b0010);
    BtnStart = 1'b0;
    BtnStop  = 1'b0;
    BtnReset = 1'b0;
    step(10);
    check("all_no_start", n_start, 3);
    check("all_no_stop", n_stop, 1);
    check("all_one_clear", n_clear, 1);

    press(2, 6);
    check("reset_btn_first_clear", n_clear, 2);
    press(2, 6);
    check("reset_btn_second_clear", n_clear, 3);
    check("reset_btn_running", Running, 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
